// File: rtl/piano_voice_sequencer.sv
// rtl/piano_voice_sequencer.sv - time-multiplexed wave-ROM voice mixer for piano keys
// One ROM read per pressed key each sample period; samples are summed and saturated onto wave.
module piano_voice_sequencer #(
   parameter int NUM_KEYS   = 8,
   parameter int PHASE_W    = 16,
   parameter int ADDR_W     = 8,
   parameter int SAMPLE_W   = 8,
   parameter int SAMPLE_DIV = 1024,
   localparam int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                inc_we,
   input  logic [IDX_W-1:0]    inc_sel,
   input  logic [PHASE_W-1:0]  inc_data,
   output logic                rom_en,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [SAMPLE_W-1:0] rom_data,
   output logic [SAMPLE_W-1:0] wave,
   output logic                wave_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int ACC_W = SAMPLE_W + IDX_W;

   typedef enum logic [1:0] {IDLE, SCAN, WAIT, OUTPUT} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                tick;
   logic [NUM_KEYS-1:0] chord;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_nx;
   logic                last;
   logic [ACC_W-1:0]    acc;
   logic [PHASE_W-1:0]  phase [NUM_KEYS];
   logic [PHASE_W-1:0]  inc   [NUM_KEYS];

   assign tick   = (cnt == CNT_W'(SAMPLE_DIV - 1));
   assign idx_nx = idx + IDX_W'(1);
   assign last   = (idx == IDX_W'(NUM_KEYS - 1));
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            inc[i] <= '0;
         end
      end else if (inc_we) begin
         inc[inc_sel] <= inc_data;
      end
   end

   // rom_en/rom_addr are registered one step ahead so they are high exactly in the SCAN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         chord      <= '0;
         idx        <= '0;
         acc        <= '0;
         wave       <= '0;
         wave_valid <= 1'b0;
         rom_en     <= 1'b0;
         rom_addr   <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            phase[i] <= '0;
         end
      end else begin
         wave_valid <= 1'b0;
         rom_en     <= 1'b0;
         rom_addr   <= '0;
         if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (tick) begin
                  chord    <= keys;
                  idx      <= '0;
                  acc      <= '0;
                  rom_en   <= keys[0];
                  rom_addr <= phase[0][PHASE_W-1 -: ADDR_W];
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (chord[idx]) begin
                  phase[idx] <= phase[idx] + inc[idx];
                  state      <= WAIT;
               end else begin
                  // a released key restarts its note from phase 0
                  phase[idx] <= '0;
                  if (last) begin
                     state <= OUTPUT;
                  end else begin
                     idx      <= idx_nx;
                     rom_en   <= chord[idx_nx];
                     rom_addr <= phase[idx_nx][PHASE_W-1 -: ADDR_W];
                  end
               end
            end
            WAIT: begin
               acc <= acc + ACC_W'(rom_data);
               if (last) begin
                  state <= OUTPUT;
               end else begin
                  idx      <= idx_nx;
                  rom_en   <= chord[idx_nx];
                  rom_addr <= phase[idx_nx][PHASE_W-1 -: ADDR_W];
                  state    <= SCAN;
               end
            end
            OUTPUT: begin
               wave       <= (|acc[ACC_W-1:SAMPLE_W]) ? '1 : acc[SAMPLE_W-1:0];
               wave_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piano_voice_sequencer.sv
// tb/tb_piano_voice_sequencer.sv - randomized self-checking bench for piano_voice_sequencer
module tb_piano_voice_sequencer;
   localparam int N    = 8;
   localparam int DIV  = 40;
   localparam int ODIV = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] keys;
   logic       inc_we;
   logic [2:0] inc_sel;
   logic [15:0] inc_data;
   logic       rom_en;
   logic [7:0] rom_addr;
   logic [7:0] rom_data = 8'd0;
   logic [7:0] wave;
   logic       wave_valid, busy, overrun;

   logic       o_rom_en;
   logic [7:0] o_rom_addr;
   logic [7:0] o_rom_data = 8'd0;
   logic [7:0] o_wave;
   logic       o_wave_valid, o_busy, o_overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rom_mode = 0;
   logic [7:0] rom_tab [256];
   int m_phase [N];
   int m_inc [N];

   always #5 clk = ~clk;

   piano_voice_sequencer #(.NUM_KEYS(N), .PHASE_W(16), .ADDR_W(8), .SAMPLE_W(8), .SAMPLE_DIV(DIV)) u_dut (
      .clk(clk), .rst(rst), .keys(keys), .inc_we(inc_we), .inc_sel(inc_sel), .inc_data(inc_data),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .wave(wave),
      .wave_valid(wave_valid), .busy(busy), .overrun(overrun));

   piano_voice_sequencer #(.NUM_KEYS(N), .PHASE_W(16), .ADDR_W(8), .SAMPLE_W(8), .SAMPLE_DIV(ODIV)) u_ovr (
      .clk(clk), .rst(rst), .keys(8'hFF), .inc_we(1'b0), .inc_sel(3'd0), .inc_data(16'd0),
      .rom_en(o_rom_en), .rom_addr(o_rom_addr), .rom_data(o_rom_data), .wave(o_wave),
      .wave_valid(o_wave_valid), .busy(o_busy), .overrun(o_overrun));

   function automatic int rom_val(input int a);
      case (rom_mode)
         0:       return a;
         1:       return 192;
         default: return int'(rom_tab[a]);
      endcase
   endfunction

   always @(posedge clk) if (rom_en) rom_data <= 8'(rom_val(int'(rom_addr)));
   always @(posedge clk) if (o_rom_en) o_rom_data <= 8'hC0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < N; i++) begin
         m_phase[i] = 0;
         m_inc[i] = 0;
      end
   endtask

   task automatic set_inc(input int sel, input int data);
      inc_we = 1'b1;
      inc_sel = 3'(sel);
      inc_data = 16'(data);
      step();
      inc_we = 1'b0;
      m_inc[sel] = data;
   endtask

   // One sample frame: the model predicts read addresses, sum and pulse timing from the key rules.
   task automatic frame(input logic [7:0] k, input bit scramble, input int coll_off, input int coll_sel, input int coll_data);
      int t, kc, sum, exp_wave, vcyc, npulse, nbusy, vwave;
      int exp_addr[$];
      int got_addr[$];
      while ((cyc % DIV) != DIV - 1) step();
      keys = k;
      t = cyc;
      kc = 0;
      sum = 0;
      for (int i = 0; i < N; i++) begin
         if (k[i]) begin
            exp_addr.push_back(m_phase[i] / 256);
            sum += rom_val(m_phase[i] / 256);
            m_phase[i] = (m_phase[i] + m_inc[i]) % 65536;
            kc++;
         end else begin
            m_phase[i] = 0;
         end
      end
      if (coll_off >= 0) m_inc[coll_sel] = coll_data;
      exp_wave = (sum > 255) ? 255 : sum;
      chk("busy_at_tick", busy, 0);
      vcyc = -1;
      npulse = 0;
      nbusy = 0;
      vwave = -1;
      while (cyc < t + N + kc + 4) begin
         step();
         if (scramble) keys = 8'($urandom);
         if (coll_off >= 0 && cyc == t + coll_off) begin
            inc_we = 1'b1;
            inc_sel = 3'(coll_sel);
            inc_data = 16'(coll_data);
         end else begin
            inc_we = 1'b0;
         end
         if (busy) nbusy++;
         if (rom_en) got_addr.push_back(int'(rom_addr));
         if (wave_valid) begin
            npulse++;
            vcyc = cyc - t;
            vwave = int'(wave);
         end
      end
      chk("rom_reads", got_addr.size(), kc);
      for (int j = 0; j < kc && j < got_addr.size(); j++) chk("rom_addr", got_addr[j], exp_addr[j]);
      chk("valid_latency", vcyc, N + kc + 2);
      chk("valid_pulses", npulse, 1);
      chk("busy_cycles", nbusy, N + kc + 1);
      chk("wave", vwave, exp_wave);
      chk("wave_hold", wave, exp_wave);
   endtask

   initial begin #1000000; $display("FAIL watchdog timeout"); $fatal(1); end

   initial begin
      int first_busy, first_valid, ign, free, t, npulse;
      int o_exp[$];
      int o_got[$];
      int o_wv[$];
      rst = 1'b1;
      keys = 8'h00;
      inc_we = 1'b0;
      inc_sel = 3'd0;
      inc_data = 16'd0;
      for (int i = 0; i < 256; i++) rom_tab[i] = 8'($urandom);

      do_reset();
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_wave", wave, 0);
      chk("rst_wave_valid", wave_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_o_overrun", o_overrun, 0);

      // fast-divider instance: frames of 18 cycles against a 12-cycle tick
      ign = -1;
      free = 0;
      for (int tk = ODIV - 1; tk < 78; tk += ODIV) begin
         if (tk >= free) begin
            o_exp.push_back(tk + 2 * N + 2);
            free = tk + 2 * N + 2;
         end else if (ign < 0) begin
            ign = tk;
         end
      end
      first_busy = -1;
      first_valid = -1;
      while (cyc < 78) begin
         step();
         if (busy && first_busy < 0) first_busy = cyc;
         if (wave_valid && first_valid < 0) first_valid = cyc;
         if (o_wave_valid) begin
            o_got.push_back(cyc);
            o_wv.push_back(int'(o_wave));
         end
         if (cyc == ign) chk("o_overrun_before", o_overrun, 0);
         if (cyc == ign + 1) chk("o_overrun_after", o_overrun, 1);
      end
      chk("first_tick_busy", first_busy, DIV);
      chk("silent_valid", first_valid, DIV - 1 + N + 2);
      chk("o_pulse_count", o_got.size(), o_exp.size());
      for (int j = 0; j < o_exp.size() && j < o_got.size(); j++) begin
         chk("o_pulse_cycle", o_got[j], o_exp[j]);
         chk("o_wave_sat", o_wv[j], 255);
      end

      rom_mode = 0;
      set_inc(2, 16'h0100);
      repeat (4) frame(8'h04, 1'b0, -1, 0, 0);

      rom_mode = 1;
      for (int i = 0; i < N; i++) set_inc(i, int'($urandom_range(0, 65535)));
      repeat (2) frame(8'hFF, 1'b1, -1, 0, 0);

      rom_mode = 2;
      frame(8'h00, 1'b1, -1, 0, 0);
      set_inc(5, int'($urandom_range(256, 65535)));
      frame(8'h20, 1'b0, -1, 0, 0);
      frame(8'h20, 1'b0, -1, 0, 0);
      frame(8'h00, 1'b0, -1, 0, 0);
      frame(8'h20, 1'b0, -1, 0, 0);

      for (int r = 0; r < 10; r++) begin
         if (r % 3 == 0) set_inc(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)));
         frame(8'($urandom), 1'b1, -1, 0, 0);
      end

      rom_mode = 0;
      frame(8'h00, 1'b0, -1, 0, 0);
      set_inc(3, 16'h0100);
      frame(8'h08, 1'b0, 4, 3, 16'h0300);
      frame(8'h08, 1'b0, -1, 0, 0);
      frame(8'h08, 1'b0, -1, 0, 0);
      chk("main_no_overrun", overrun, 0);

      set_inc(0, 16'h1000);
      while ((cyc % DIV) != DIV - 1) step();
      keys = 8'h01;
      t = cyc;
      step();
      step();
      chk("wait_rom_en", rom_en, 0);
      chk("wait_busy", busy, 1);
      npulse = 0;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (wave_valid) npulse++;
      end
      rst = 1'b0;
      cyc = 0;
      repeat (20) begin
         step();
         if (wave_valid) npulse++;
      end
      chk("midrst_pulses", npulse, 0);
      chk("midrst_wave", wave, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rom_en", rom_en, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
